counter_input_conditioner: RTL

- Upstream front end for the programmable up/down counter.
- Takes the raw asynchronous control pins (external count clock, enable, load, up/down) and the 8-bit preset bus. Synchronises them to clk and debounces the control bits.
- Emits clean single-cycle count_tick and load_pulse strobes, stable level outputs, and a load value captured at the load instant.
- The counter consumes only these outputs and never sees raw pins.

---
 rtl/counter_pkg.sv | 11 +
 rtl/sync_debounce.sv | 33 +++
 rtl/counter_input_conditioner.sv | 63 ++++++
 3 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared defaults and control pin map for the counter input conditioner
package counter_pkg;
    localparam int DEF_DATA_W          = 8;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int N_PINS      = 4;
    localparam int PIN_ENABLE  = 0;
    localparam int PIN_CLK_IN  = 1;
    localparam int PIN_LOAD    = 2;
    localparam int PIN_UP_DOWN = 3;
endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: synchroniser chain followed by a hold-time debounce filter for one bit
module sync_debounce
    import counter_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            if (sync[SYNC_STAGES-1] == dout) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                dout <= sync[SYNC_STAGES-1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/counter_input_conditioner.sv
// counter_input_conditioner: cleans raw counter pins into debounced levels, strobes and a captured preset
module counter_input_conditioner
    import counter_pkg::*;
#(
    parameter int DATA_W          = DEF_DATA_W,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_clk_in,
    input  logic              enable_in,
    input  logic              load_in,
    input  logic              up_down_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              count_tick,
    output logic              load_pulse,
    output logic [DATA_W-1:0] load_data,
    output logic              up_down,
    output logic              enable
);
    logic [N_PINS-1:0] raw, db;
    logic [DATA_W-1:0] dsync [SYNC_STAGES];
    logic              clk_q, load_q, rise_clk, rise_load;
    assign raw[PIN_ENABLE]  = enable_in;
    assign raw[PIN_CLK_IN]  = ext_clk_in;
    assign raw[PIN_LOAD]    = load_in;
    assign raw[PIN_UP_DOWN] = up_down_in;
    for (genvar i = 0; i < N_PINS; i++) begin : g_pin
        sync_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_sd (
            .clk (clk),
            .rst (rst),
            .din (raw[i]),
            .dout(db[i])
        );
    end
    assign enable    = db[PIN_ENABLE];
    assign up_down   = db[PIN_UP_DOWN];
    assign rise_clk  = db[PIN_CLK_IN] & ~clk_q;
    assign rise_load = db[PIN_LOAD] & ~load_q;
    // load wins a same-cycle collision; the lost tick is dropped, not deferred
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dsync      <= '{default: '0};
            clk_q      <= 1'b0;
            load_q     <= 1'b0;
            count_tick <= 1'b0;
            load_pulse <= 1'b0;
            load_data  <= '0;
        end else begin
            dsync[0] <= data_in;
            for (int k = 1; k < SYNC_STAGES; k++) dsync[k] <= dsync[k-1];
            clk_q      <= db[PIN_CLK_IN];
            load_q     <= db[PIN_LOAD];
            count_tick <= rise_clk & db[PIN_ENABLE] & ~rise_load;
            load_pulse <= rise_load;
            if (rise_load) load_data <= dsync[SYNC_STAGES-1];
        end
    end
endmodule
